// File: rtl/axi_txn_run_sequencer_if.sv
// Bus bundle between the run sequencer, its test-control side and one AXI traffic controller.
// The slave modport is the sequencer's view; master is the control/controller side.
interface axi_txn_run_sequencer_if #(
    parameter int unsigned RUN_W = 16,
    parameter int unsigned GAP_W = 8
);
    logic             START;
    logic [RUN_W-1:0] NUM_RUNS;
    logic [GAP_W-1:0] GAP;
    logic             STOP_ON_ERR;
    logic             ABORT;
    logic             M_AXI_INIT_AXI_TXN;
    logic             M_AXI_TXN_DONE;
    logic             M_AXI_ERROR;
    logic             BUSY;
    logic             SEQ_DONE;
    logic             PASS;
    logic [RUN_W-1:0] RUN_COUNT;
    logic [RUN_W-1:0] ERR_COUNT;
    logic             TIMEOUT_ERR;
    logic             ABORTED;

    modport slave (
        input  START, NUM_RUNS, GAP, STOP_ON_ERR, ABORT, M_AXI_TXN_DONE, M_AXI_ERROR,
        output M_AXI_INIT_AXI_TXN, BUSY, SEQ_DONE, PASS, RUN_COUNT, ERR_COUNT,
               TIMEOUT_ERR, ABORTED
    );

    modport master (
        output START, NUM_RUNS, GAP, STOP_ON_ERR, ABORT, M_AXI_TXN_DONE, M_AXI_ERROR,
        input  M_AXI_INIT_AXI_TXN, BUSY, SEQ_DONE, PASS, RUN_COUNT, ERR_COUNT,
               TIMEOUT_ERR, ABORTED
    );
endinterface

// File: rtl/axi_txn_run_sequencer.sv
// Run sequencer: launches a programmed number of traffic-controller runs with an inter-run gap
// and per-run watchdog, accumulating run/error counts and a final pass/fail verdict.
module axi_txn_run_sequencer #(
    parameter int unsigned RUN_W          = 16,
    parameter int unsigned GAP_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                    ACLK,
    input logic                    ARESETN,
    axi_txn_run_sequencer_if.slave bus
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_RUN, S_CHECK, S_FINISH} state_e;

    state_e           state_q, state_n;
    logic [RUN_W-1:0] num_runs_q, num_runs_n;
    logic [GAP_W-1:0] gap_q, gap_n;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_n;
    logic             stop_on_err_q, stop_on_err_n;
    logic [WD_W-1:0]  wd_q, wd_n;
    logic             done_q;
    logic             err_q, err_n;
    logic             init_q, init_n;
    logic             busy_q, busy_n;
    logic             seq_done_q, seq_done_n;
    logic             pass_q, pass_n;
    logic             timeout_q, timeout_n;
    logic             aborted_q, aborted_n;
    logic [RUN_W-1:0] run_count_q, run_count_n;
    logic [RUN_W-1:0] err_count_q, err_count_n;
    logic             done_edge_c;
    logic [GAP_W-1:0] start_gap_c;

    assign done_edge_c = bus.M_AXI_TXN_DONE & ~done_q;
    assign start_gap_c = (bus.GAP == '0) ? GAP_W'(1) : bus.GAP;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= S_IDLE;
        else          state_q <= state_n;
    end

    always_comb begin
        state_n       = state_q;
        num_runs_n    = num_runs_q;
        gap_n         = gap_q;
        gap_cnt_n     = gap_cnt_q;
        stop_on_err_n = stop_on_err_q;
        wd_n          = wd_q;
        err_n         = err_q;
        seq_done_n    = 1'b0;
        pass_n        = pass_q;
        timeout_n     = timeout_q;
        aborted_n     = aborted_q;
        run_count_n   = run_count_q;
        err_count_n   = err_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    num_runs_n    = bus.NUM_RUNS;
                    gap_n         = start_gap_c;
                    stop_on_err_n = bus.STOP_ON_ERR;
                    run_count_n   = '0;
                    err_count_n   = '0;
                    timeout_n     = 1'b0;
                    aborted_n     = 1'b0;
                    pass_n        = 1'b0;
                    if (bus.NUM_RUNS == '0) begin
                        state_n = S_FINISH;
                    end else begin
                        state_n   = S_GAP;
                        gap_cnt_n = start_gap_c;
                    end
                end
            end
            S_GAP: begin
                if (bus.ABORT) begin
                    aborted_n = 1'b1;
                    state_n   = S_FINISH;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_n = S_RUN;
                    wd_n    = WD_W'(1);
                end else begin
                    gap_cnt_n = gap_cnt_q - GAP_W'(1);
                end
            end
            // Abort outranks a same-cycle done-edge or timeout; done-edge outranks timeout.
            S_RUN: begin
                if (bus.ABORT) begin
                    aborted_n = 1'b1;
                    state_n   = S_FINISH;
                end else if (done_edge_c) begin
                    err_n   = bus.M_AXI_ERROR;
                    state_n = S_CHECK;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES)) begin
                    timeout_n = 1'b1;
                    state_n   = S_FINISH;
                end else begin
                    wd_n = wd_q + WD_W'(1);
                end
            end
            S_CHECK: begin
                run_count_n = run_count_q + RUN_W'(1);
                if (err_q && (err_count_q != '1)) err_count_n = err_count_q + RUN_W'(1);
                if (bus.ABORT) begin
                    aborted_n = 1'b1;
                    state_n   = S_FINISH;
                end else if (run_count_n == num_runs_q) begin
                    state_n = S_FINISH;
                end else if (err_q && stop_on_err_q) begin
                    state_n = S_FINISH;
                end else begin
                    state_n   = S_GAP;
                    gap_cnt_n = gap_q;
                end
            end
            S_FINISH: begin
                seq_done_n = 1'b1;
                pass_n     = (err_count_q == '0) & ~timeout_q & ~aborted_q;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        init_n = (state_n == S_RUN) || (state_n == S_CHECK);
        busy_n = (state_n != S_IDLE);
    end

    // Datapath and registered outputs, all advanced from the next-state logic.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            num_runs_q    <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            stop_on_err_q <= 1'b0;
            wd_q          <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            init_q        <= 1'b0;
            busy_q        <= 1'b0;
            seq_done_q    <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            aborted_q     <= 1'b0;
            run_count_q   <= '0;
            err_count_q   <= '0;
        end else begin
            num_runs_q    <= num_runs_n;
            gap_q         <= gap_n;
            gap_cnt_q     <= gap_cnt_n;
            stop_on_err_q <= stop_on_err_n;
            wd_q          <= wd_n;
            done_q        <= bus.M_AXI_TXN_DONE;
            err_q         <= err_n;
            init_q        <= init_n;
            busy_q        <= busy_n;
            seq_done_q    <= seq_done_n;
            pass_q        <= pass_n;
            timeout_q     <= timeout_n;
            aborted_q     <= aborted_n;
            run_count_q   <= run_count_n;
            err_count_q   <= err_count_n;
        end
    end

    assign bus.M_AXI_INIT_AXI_TXN = init_q;
    assign bus.BUSY               = busy_q;
    assign bus.SEQ_DONE           = seq_done_q;
    assign bus.PASS               = pass_q;
    assign bus.RUN_COUNT          = run_count_q;
    assign bus.ERR_COUNT          = err_count_q;
    assign bus.TIMEOUT_ERR        = timeout_q;
    assign bus.ABORTED            = aborted_q;
endmodule

// File: doc/axi_txn_run_sequencer.md
# axi_txn_run_sequencer

Run sequencer for the AXI master traffic-controller IP. It drives the controller's M_AXI_INIT_AXI_TXN launch input and monitors M_AXI_TXN_DONE and M_AXI_ERROR. It executes a programmed number of back-to-back test runs with an inter-run gap and a per-run watchdog, and accumulates run and error counts plus a final pass/fail verdict. It sits between the test-control logic (or a bench) and one traffic-controller instance, all on ACLK.

## Interface
- RUN_W, 16, width of run-count fields.
- GAP_W, 8, width of inter-run gap field.
- TIMEOUT_CYCLES, 4096, maximum ACLK cycles a run may take before the watchdog fires; must be ≥ 2.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- START  in  1  level-sampled in IDLE only; starts a sequence.
- NUM_RUNS  in  RUN_W  runs to execute; latched on START acceptance.
- GAP  in  GAP_W  cycles INIT is held low before each run; 0 is treated as 1; latched on START.
- STOP_ON_ERR  in  1  end the sequence after the first failing run; latched on START.
- ABORT  in  1  terminate the sequence; ignored in IDLE and FINISH.
- M_AXI_INIT_AXI_TXN  out  1  launch level to the traffic controller; rising edge starts a run.
- M_AXI_TXN_DONE  in  1  run-complete level from the controller.
- M_AXI_ERROR  in  1  run-error level from the controller; valid when DONE rises.
- BUSY  out  1  high in every state except IDLE.
- SEQ_DONE  out  1  one-cycle pulse when the sequence ends.
- PASS  out  1  verdict; valid from SEQ_DONE until the next START acceptance.
- RUN_COUNT  out  RUN_W  completed runs, including failing runs and excluding timed-out runs.
- ERR_COUNT  out  RUN_W  runs completed with M_AXI_ERROR=1; saturates at all-ones.
- TIMEOUT_ERR  out  1  sticky; a run hit the watchdog.
- ABORTED  out  1  sticky; the sequence was ended by ABORT.

## Operation
- States: IDLE, GAP, RUN, CHECK, FINISH.
- IDLE: INIT=0. START=1 latches the parameters and clears RUN_COUNT, ERR_COUNT, TIMEOUT_ERR, ABORTED and PASS.
  - NUM_RUNS=0 → FINISH.
  - Otherwise → GAP, and the gap counter loads max(GAP,1).
- GAP: INIT=0. The counter decrements each cycle. On the cycle it reaches 1 → RUN, and the watchdog clears.
- RUN: INIT=1.
  - Done-edge = M_AXI_TXN_DONE & ~done_q, where done_q is DONE registered one cycle. A stale-high DONE left over from the previous run is therefore ignored.
  - On done-edge: capture M_AXI_ERROR into err_q → CHECK.
  - If the watchdog reaches TIMEOUT_CYCLES without a done-edge: set TIMEOUT_ERR → FINISH.
- CHECK: INIT=1 (held); RUN_COUNT+1, and ERR_COUNT+1 if err_q. Next state:
  - FINISH if RUN_COUNT+1 == NUM_RUNS;
  - else FINISH if err_q & STOP_ON_ERR;
  - else GAP, reloading the gap counter.
- FINISH: INIT=0 and SEQ_DONE=1 for exactly one cycle. PASS ← (ERR_COUNT==0 & ~TIMEOUT_ERR & ~ABORTED), using the values updated in CHECK. Then → IDLE.
- ABORT=1 in GAP, RUN or CHECK: set ABORTED → FINISH next cycle.
  - Abort in CHECK still applies that cycle's count update.
  - ABORT takes priority over a simultaneous done-edge or timeout. That done-edge is not counted; a simultaneous timeout does not set TIMEOUT_ERR.
- START while BUSY is ignored. START held high through FINISH re-triggers from IDLE on the following cycle.

## Timing
- Reset (ARESETN=0, asynchronous): state=IDLE, done_q=0, err_q=0. All outputs are 0: INIT, BUSY, SEQ_DONE, PASS, RUN_COUNT, ERR_COUNT, TIMEOUT_ERR, ABORTED. Reset deassertion is assumed synchronised upstream. Reset mid-run drops INIT immediately.
- All outputs are registered.
- START at cycle t → BUSY=1 at t+1. The first INIT rise is at t+1+max(GAP,1).
- Done-edge seen in RUN at cycle d → counts update at d+2 (visible after CHECK at d+1). INIT falls at d+2.
- Per-run overhead outside the controller is max(GAP,1)+1 cycles, with INIT low ≥ 1 cycle between runs. This guarantees a rising edge for every run.
- Watchdog counts RUN cycles from 1. A timeout at count TIMEOUT_CYCLES gives INIT=0 on the next cycle.

## Test plan
- NUM_RUNS=3, GAP=4, controller model DONE rising 20 cycles after INIT, ERROR=0 → three INIT pulses, each preceded by 4 low cycles; SEQ_DONE once; RUN_COUNT=3, ERR_COUNT=0, PASS=1.
- NUM_RUNS=4, STOP_ON_ERR=0, ERROR=1 on run 2 only → RUN_COUNT=4, ERR_COUNT=1, PASS=0.
- Same stimulus with STOP_ON_ERR=1 → SEQ_DONE after run 2; RUN_COUNT=2, ERR_COUNT=1, PASS=0; no third INIT rise.
- TIMEOUT_CYCLES=64, model never raises DONE on run 1 → INIT low by RUN cycle 65; TIMEOUT_ERR=1, RUN_COUNT=0, PASS=0.
- NUM_RUNS=0 → INIT never rises; SEQ_DONE two cycles after START; PASS=1. Separately, DONE held high from a prior run at START with NUM_RUNS=1 → no run is counted until DONE falls and re-rises.
- ABORT in RUN of run 2 with a simultaneous done-edge → ABORTED=1, RUN_COUNT=1, PASS=0. ARESETN pulsed low mid-RUN → INIT and all outputs are 0 asynchronously; START then works normally.
